// File: rtl/uart_tx_serializer.sv
// Framed asynchronous serial transmitter: start bit, DBIT data bits LSB-first, one stop bit.
// All outputs come straight from flops, so the line is glitch-free.
module uart_tx_serializer #(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DBIT-1:0] sreg_q, sreg_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  // tx_d is the line level for the *next* state, so tx_q lines up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          sreg_d  = din;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = sreg_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
          tx_d  = 1'b0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          sreg_d = sreg_q >> 1;
          if (idx_q == IDX_MAX) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
            tx_d  = sreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          tx_d  = sreg_q[0];
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    // Flags are registered from the next-state view so they align with state_q.
    ready_d = (state_d == IDLE);
    done_d  = (state_d == STOP) && (cnt_d == CNT_MAX);
  end

  // State and output registers; reset drives the line high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_ready     = ready_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: expected per-cycle line levels are queued when a frame is launched
// and popped each clock as the transmitter produces them.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_ready, tx_done_tick, tx;
  logic       tx_start2 = 1'b0;
  logic [4:0] din2 = 5'h00;
  logic       tx_ready2, tx_done_tick2, tx2;

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];

  uart_tx_serializer #(.DBIT(8), .CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .din(din),
    .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  uart_tx_serializer #(.DBIT(5), .CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start2), .din(din2),
    .tx_ready(tx_ready2), .tx_done_tick(tx_done_tick2), .tx(tx2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic push_frame(input logic [15:0] d, input int dbit, input int clks);
    for (int i = 0; i < clks; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < dbit; b++)
      for (int i = 0; i < clks; i++) exp_q.push_back(d[b]);
    for (int i = 0; i < clks; i++) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got tx=%b ready=%b done=%b expected 1 1 0", tx, tx_ready, tx_done_tick);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_line: cycle %0d got tx=%b expected 1", k, tx);
      end
    end
  endtask

  task automatic test_single_frame();
    int done_cnt = 0;
    int ready_low = 0;
    bit e;
    exp_q.delete();
    @(negedge clk);
    din = 8'hA5;
    tx_start = 1'b1;
    push_frame(16'h00A5, 8, 4);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) tx_start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (tx !== e) begin
        miscompares++;
        $display("FAIL single_tx: cycle %0d got %b expected %b", k, tx, e);
      end
      if (tx_done_tick === 1'b1) done_cnt++;
      if (tx_ready === 1'b0) ready_low++;
      if (k == 40) begin
        vectors++;
        if (tx_done_tick !== 1'b1) begin
          miscompares++;
          $display("FAIL single_done_pos: cycle 40 got %b expected 1", tx_done_tick);
        end
      end
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL single_done_count: got %0d expected 1", done_cnt);
    end
    vectors++;
    if (ready_low != 40) begin
      miscompares++;
      $display("FAIL single_ready_low: got %0d expected 40", ready_low);
    end
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL single_return_idle: got ready=%b tx=%b expected 1 1", tx_ready, tx);
    end
  endtask

  task automatic test_busy_ignore();
    bit e;
    exp_q.delete();
    @(negedge clk);
    din = 8'h3C;
    tx_start = 1'b1;
    push_frame(16'h003C, 8, 4);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (tx !== e) begin
        miscompares++;
        $display("FAIL busy_tx: cycle %0d got %b expected %b", k, tx, e);
      end
      if (k == 1) tx_start = 1'b0;
      if (k == 12) begin
        tx_start = 1'b1;
        din = 8'hFF;
      end
      if (k == 13) tx_start = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1 || tx_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_no_second: cycle %0d got tx=%b ready=%b expected 1 1", k, tx, tx_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    int run = 0;
    exp_q.delete();
    @(negedge clk);
    din = 8'h00;
    tx_start = 1'b1;
    push_frame(16'h0000, 8, 4);
    exp_q.push_back(1'b1);
    push_frame(16'h00FF, 8, 4);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (tx !== e) begin
        miscompares++;
        $display("FAIL b2b_tx: cycle %0d got %b expected %b", k, tx, e);
      end
      run = (tx === 1'b1) ? run + 1 : 0;
      vectors++;
      if (tx_done_tick !== ((k == 40) || (k == 81))) begin
        miscompares++;
        $display("FAIL b2b_done: cycle %0d got %b expected %b", k, tx_done_tick, (k == 40) || (k == 81));
      end
      if (k == 41) begin
        vectors++;
        if (run != 5 || tx_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_gap: got high_run=%0d ready=%b expected 5 1", run, tx_ready);
        end
      end
      if (k == 20) din = 8'hFF;
      if (k == 42) tx_start = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_end_idle: got ready=%b tx=%b expected 1 1", tx_ready, tx);
    end
  endtask

  task automatic test_reset_midframe();
    bit e;
    int done_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    din = 8'h5A;
    tx_start = 1'b1;
    push_frame(16'h005A, 8, 4);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) tx_start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (tx !== e) begin
        miscompares++;
        $display("FAIL abort_pre_tx: cycle %0d got %b expected %b", k, tx, e);
      end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async: got tx=%b ready=%b done=%b expected 1 1 0", tx, tx_ready, tx_done_tick);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx_done_tick === 1'b1) done_cnt++;
    end
    vectors++;
    if (done_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d ticks expected 0", done_cnt);
    end
    exp_q.delete();
    din = 8'h5A;
    tx_start = 1'b1;
    push_frame(16'h005A, 8, 4);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) tx_start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (tx !== e || tx_done_tick !== (k == 40)) begin
        miscompares++;
        $display("FAIL abort_refresh: cycle %0d got tx=%b done=%b expected %b %b", k, tx, tx_done_tick, e, k == 40);
      end
    end
  endtask

  task automatic test_param_sweep();
    bit e;
    exp_q.delete();
    @(negedge clk);
    din2 = 5'b10011;
    tx_start2 = 1'b1;
    push_frame(16'h0013, 5, 2);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) tx_start2 = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (tx2 !== e || tx_ready2 !== 1'b0 || tx_done_tick2 !== (k == 14)) begin
        miscompares++;
        $display("FAIL sweep_tx: cycle %0d got tx=%b ready=%b done=%b expected %b 0 %b",
                 k, tx2, tx_ready2, tx_done_tick2, e, k == 14);
      end
    end
    @(negedge clk);
    vectors++;
    if (tx_ready2 !== 1'b1 || tx2 !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_end_idle: got ready=%b tx=%b expected 1 1", tx_ready2, tx2);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Serial transmitter: accepts a parallel byte via a single-cycle start handshake and shifts it out LSB-first as a framed asynchronous serial stream (start bit, DBIT data bits, one stop bit). It is the transmit end for the team's enabled-flop serial capture path, and the producer of the line that a matching receiver samples. All state uses a registered state/next-state structure. The serial output is driven straight from a flop, so it is glitch-free.

Parameters:
DBIT, 8, number of data bits per frame (legal range 5..16)
CLKS_PER_BIT, 16, clock cycles per serial bit period (legal range >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces all state to reset values immediately
tx_start  input  1  request to send; sampled only when tx_ready=1
din  input  DBIT  parallel data word; captured in the same cycle tx_start is accepted
tx_ready  output  1  high when idle and able to accept tx_start
tx_done_tick  output  1  one-cycle pulse in the final clock of the stop bit
tx  output  1  serial line, idle high, registered

Behaviour:
- Reset values: state=IDLE, tx=1, tx_ready=1, tx_done_tick=0, bit-period counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame. tx returns to 1 asynchronously. No done tick is issued.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, tx_ready=1.
  - If tx_start=1 at a rising edge, latch din into the shift register, clear the counter, and go to START.
  - If tx_start=0, stay in IDLE.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - Then clear the counter, set bit index=0, and go to DATA.
- DATA:
  - tx = shift register bit 0 for CLKS_PER_BIT cycles.
  - At the end of each bit period, shift the register right by 1 and increment the bit index.
  - After bit index DBIT-1 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done_tick=1 in the last cycle of STOP only.
  - Next state is IDLE.
- tx is a registered output. It changes on the same edge as the state transition, so tx goes low on the first edge after tx_start is accepted (1-cycle latency).
- Frame length, from the acceptance edge to the return to IDLE: (DBIT+2)*CLKS_PER_BIT cycles.
- tx_ready=0 in START, DATA and STOP. tx_start while busy is ignored, with no queueing. din changes while busy have no effect.
- Back-to-back frames: the earliest new acceptance is the first IDLE cycle after tx_done_tick. The line therefore stays high for at least CLKS_PER_BIT+1 cycles between frames.
- Counter width: clog2(CLKS_PER_BIT). The counter wraps to 0 at CLKS_PER_BIT-1, and never counts past that value.
- Bit index width: clog2(DBIT).
- tx_start held high continuously starts a new frame on each IDLE entry.
- No X propagation: every state register has an explicit reset and an explicit next-state default (hold).

Test Plan:
- Reset check: assert reset for 3 cycles, then release -> tx=1, tx_ready=1, tx_done_tick=0. Hold idle for 20 cycles -> tx stays 1.
- Single frame (CLKS_PER_BIT=4, DBIT=8): din=0xA5 with a 1-cycle tx_start.
  - tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - tx_done_tick high exactly once, in cycle 40 after acceptance.
  - tx_ready low for exactly 40 cycles.
- Busy-ignore: start 0x3C, then pulse tx_start with din=0xFF in the middle of DATA -> serialized bits still 0,0,1,1,1,1,0,0 and no second frame follows.
- Back-to-back: hold tx_start=1 with din=0x00 then 0xFF -> second frame's start bit begins exactly 1 cycle after tx_done_tick. Stop-bit high time measures 5 cycles.
- Reset mid-frame: assert reset during bit 3 of DATA -> tx=1 before the next clock edge and no tx_done_tick. A new tx_start after release sends a full, correct frame.
- Parameter sweep: DBIT=5, CLKS_PER_BIT=2, din=5'b10011 -> frame is 14 cycles and data bits are 1,1,0,0,1.
